// File: rtl/glitc_config_pkg.sv
// glitc_config_pkg: shared state encodings, register addresses and bit offsets for GLITC configuration
package glitc_config_pkg;
  typedef enum logic [2:0] {
    ST_UNCONF    = 3'd0,
    ST_PROG      = 3'd1,
    ST_WAIT_INIT = 3'd2,
    ST_LOAD      = 3'd3,
    ST_READY     = 3'd4,
    ST_FAULT     = 3'd5
  } gstate_e;
  localparam logic [1:0] ADR_CTRL = 2'd0;
  localparam logic [1:0] ADR_FAULT = 2'd1;
  localparam int FLT_TO_LSB = 0;
  localparam int FLT_CRC_LSB = 4;
  localparam int STAT_GREADY_LSB = 0;
  localparam int STAT_DONE_LSB = 4;
  localparam int STAT_INIT_LSB = 8;
  localparam int STAT_STATE_LSB = 12;
endpackage

// File: rtl/glitc_prog_channel.sv
// glitc_prog_channel: one GLITC's PROGRAM_B sequencer with input sync, counter and sticky fault flags
module glitc_prog_channel
  import glitc_config_pkg::*;
#(
  parameter int PROG_PULSE_CYCLES = 64,
  parameter int TIMEOUT_CYCLES = 2**24,
  parameter int CNT_BITS = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       clr_to_i,
  input  logic       clr_crc_i,
  input  logic       init_b_i,
  input  logic       done_i,
  output logic       program_b_o,
  output logic       gready_o,
  output logic       init_b_s_o,
  output logic       done_s_o,
  output logic [2:0] state_o,
  output logic       to_o,
  output logic       crc_o
);
  localparam logic [CNT_BITS-1:0] PULSE_LAST = CNT_BITS'(PROG_PULSE_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] TO_LAST = CNT_BITS'(TIMEOUT_CYCLES - 1);
  gstate_e state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0] init_sync_q, init_sync_d, done_sync_q, done_sync_d;
  logic gready_q, gready_d, to_q, to_d, crc_q, crc_d;
  logic init_s, done_s, pulse_end, timeout, set_to, set_crc;
  assign init_s = init_sync_q[1];
  assign done_s = done_sync_q[1];
  assign cnt_inc = cnt_q + CNT_BITS'(1);
  assign pulse_end = cnt_q == PULSE_LAST;
  assign timeout = cnt_q == TO_LAST;
  assign program_b_o = state_q != ST_PROG;
  assign gready_o = gready_q;
  assign init_b_s_o = init_s;
  assign done_s_o = done_s;
  assign state_o = state_q;
  assign to_o = to_q;
  assign crc_o = crc_q;
  // Next state: start overrides everything; the counter only runs in the timed states and clears on exit
  always_comb begin
    init_sync_d = {init_sync_q[0], init_b_i};
    done_sync_d = {done_sync_q[0], done_i};
    state_d = state_q;
    cnt_d = '0;
    set_to = 1'b0;
    set_crc = 1'b0;
    if (start_i) state_d = ST_PROG;
    else case (state_q)
      ST_UNCONF: state_d = done_s ? ST_READY : ST_UNCONF;
      ST_PROG: begin
        state_d = pulse_end ? ST_WAIT_INIT : ST_PROG;
        cnt_d = pulse_end ? '0 : cnt_inc;
      end
      ST_WAIT_INIT: begin
        state_d = init_s ? ST_LOAD : (timeout ? ST_FAULT : ST_WAIT_INIT);
        set_to = !init_s && timeout;
        cnt_d = (init_s || timeout) ? '0 : cnt_inc;
      end
      ST_LOAD: begin
        set_crc = !init_s;
        set_to = init_s && !done_s && timeout;
        state_d = (!init_s || set_to) ? ST_FAULT : (done_s ? ST_READY : ST_LOAD);
        cnt_d = (state_d == ST_LOAD) ? cnt_inc : '0;
      end
      ST_READY: state_d = done_s ? ST_READY : ST_UNCONF;
      ST_FAULT: state_d = ST_FAULT;
      default: state_d = ST_UNCONF;
    endcase
    gready_d = state_d == ST_READY;
    to_d = set_to | (to_q & ~clr_to_i);
    crc_d = set_crc | (crc_q & ~clr_crc_i);
  end
  // State, counter, synchronisers and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_UNCONF;
      cnt_q <= '0;
      init_sync_q <= '0;
      done_sync_q <= '0;
      gready_q <= 1'b0;
      to_q <= 1'b0;
      crc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      init_sync_q <= init_sync_d;
      done_sync_q <= done_sync_d;
      gready_q <= gready_d;
      to_q <= to_d;
      crc_q <= crc_d;
    end
  end
endmodule

// File: rtl/glitc_config_ctrl.sv
// glitc_config_ctrl: register slave driving four independent GLITC configuration sequencers
module glitc_config_ctrl
  import glitc_config_pkg::*;
#(
  parameter int PROG_PULSE_CYCLES = 64,
  parameter int TIMEOUT_CYCLES = 2**24,
  parameter int CNT_BITS = 25
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [1:0]  adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic [3:0]  PROGRAM_B,
  input  logic [3:0]  INIT_B,
  input  logic [3:0]  DONE,
  output logic [3:0]  gready_o
);
  logic seen_q, seen_d, ack_q, ack_d;
  logic [31:0] dat_q, dat_d, stat, fault, rdata;
  logic req, wr;
  logic [3:0] start, clr_to, clr_crc, init_s, done_s, flt_to, flt_crc;
  logic [11:0] states;
  logic unused_dat;
  assign unused_dat = ^dat_i[31:8];
  assign req = cyc_i & stb_i & ~seen_q;
  assign wr = req & we_i;
  assign start = (wr && adr_i == ADR_CTRL) ? dat_i[3:0] : 4'h0;
  assign clr_to = (wr && adr_i == ADR_FAULT) ? dat_i[FLT_TO_LSB +: 4] : 4'h0;
  assign clr_crc = (wr && adr_i == ADR_FAULT) ? dat_i[FLT_CRC_LSB +: 4] : 4'h0;
  assign ack_o = ack_q;
  assign dat_o = dat_q;
  for (genvar c = 0; c < 4; c++) begin : g_ch
    glitc_prog_channel #(
      .PROG_PULSE_CYCLES(PROG_PULSE_CYCLES),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .CNT_BITS(CNT_BITS)
    ) u_ch (
      .clk(clk_i),
      .rst(rst_i),
      .start_i(start[c]),
      .clr_to_i(clr_to[c]),
      .clr_crc_i(clr_crc[c]),
      .init_b_i(INIT_B[c]),
      .done_i(DONE[c]),
      .program_b_o(PROGRAM_B[c]),
      .gready_o(gready_o[c]),
      .init_b_s_o(init_s[c]),
      .done_s_o(done_s[c]),
      .state_o(states[3*c +: 3]),
      .to_o(flt_to[c]),
      .crc_o(flt_crc[c])
    );
  end
  // Read mux and one-shot ack: a strobe is served once and must drop before the next is accepted
  always_comb begin
    stat = '0;
    stat[STAT_GREADY_LSB +: 4] = gready_o;
    stat[STAT_DONE_LSB +: 4] = done_s;
    stat[STAT_INIT_LSB +: 4] = init_s;
    stat[STAT_STATE_LSB +: 12] = states;
    fault = '0;
    fault[FLT_TO_LSB +: 4] = flt_to;
    fault[FLT_CRC_LSB +: 4] = flt_crc;
    rdata = (adr_i == ADR_CTRL) ? stat : (adr_i == ADR_FAULT) ? fault : '0;
    seen_d = cyc_i & stb_i;
    ack_d = req;
    dat_d = (req & ~we_i) ? rdata : dat_q;
  end
  // Bus handshake and read-data registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      seen_q <= 1'b0;
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      seen_q <= seen_d;
      ack_q <= ack_d;
      dat_q <= dat_d;
    end
  end
endmodule
